// File: rtl/key_schedule_seq.sv
// key_schedule_seq: iterative AES-128 key expansion.
// Accepts a 128-bit cipher key on start, produces one round key per clock
// into an 11-entry register file, and serves reads through a registered port.
module key_schedule_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [3:0]   rd_index,
   output logic [127:0] rk_out,
   output logic         busy,
   output logic         done,
   output logic         key_valid
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_EXPAND = 1'b1;
   localparam logic [3:0] LAST_RND  = 4'd9;
   localparam logic [3:0] MAX_IDX   = 4'd10;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant for round counter value r (0 -> first expansion round).
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd0:    v = 8'h01;
         4'd1:    v = 8'h02;
         4'd2:    v = 8'h04;
         4'd3:    v = 8'h08;
         4'd4:    v = 8'h10;
         4'd5:    v = 8'h20;
         4'd6:    v = 8'h40;
         4'd7:    v = 8'h80;
         4'd8:    v = 8'h1b;
         4'd9:    v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   logic [0:0]   state_reg;
   logic [3:0]   cnt_reg;
   logic [127:0] cur_reg;
   logic         key_valid_reg;
   logic         done_reg;
   logic [127:0] rk_out_reg;
   logic [127:0] rk_reg [0:10];

   // Round function on the previous round key held in cur_reg.
   logic [31:0]  w_a, w_b, w_c, w_d, t_word;
   logic [31:0]  n_0, n_1, n_2, n_3;
   logic [127:0] next_key;

   assign w_a      = cur_reg[127:96];
   assign w_b      = cur_reg[95:64];
   assign w_c      = cur_reg[63:32];
   assign w_d      = cur_reg[31:0];
   assign t_word   = sub_word({w_d[23:0], w_d[31:24]}) ^ {rcon(cnt_reg), 24'h0};
   assign n_0      = w_a ^ t_word;
   assign n_1      = w_b ^ n_0;
   assign n_2      = w_c ^ n_1;
   assign n_3      = w_d ^ n_2;
   assign next_key = {n_0, n_1, n_2, n_3};

   logic         accept;
   logic         wr_en;
   logic [3:0]   wr_idx;
   logic [127:0] wr_data;

   assign accept = (state_reg == ST_IDLE) && start;

   // Select the register-file write: cipher key on accept, next round key while expanding.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = 4'd0;
      wr_data = '0;
      if (accept) begin
         wr_en   = 1'b1;
         wr_idx  = 4'd0;
         wr_data = key_in;
      end else if (state_reg == ST_EXPAND) begin
         wr_en   = 1'b1;
         wr_idx  = cnt_reg + 4'd1;
         wr_data = next_key;
      end
   end

   // One write-decoded register per round key.
   genvar gi;
   generate
      for (gi = 0; gi <= 10; gi++) begin : g_rk
         localparam logic [3:0] IDX = gi;
         // Capture this entry when the write index selects it.
         always_ff @(posedge clk) begin
            if (!rst_n)
               rk_reg[gi] <= '0;
            else if (wr_en && (wr_idx == IDX))
               rk_reg[gi] <= wr_data;
         end
      end
   endgenerate

   // Control FSM: round counter, working key, completion flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= 4'd0;
         cur_reg       <= '0;
         key_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  cur_reg       <= key_in;
                  cnt_reg       <= 4'd0;
                  key_valid_reg <= 1'b0;
                  state_reg     <= ST_EXPAND;
               end
            end
            default: begin
               cur_reg <= next_key;
               if (cnt_reg == LAST_RND) begin
                  cnt_reg       <= 4'd0;
                  key_valid_reg <= 1'b1;
                  done_reg      <= 1'b1;
                  state_reg     <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
         endcase
      end
   end

   // Registered read port; indices beyond the last round key read as zero.
   always_ff @(posedge clk) begin
      if (!rst_n)
         rk_out_reg <= '0;
      else if (rd_index <= MAX_IDX)
         rk_out_reg <= rk_reg[rd_index];
      else
         rk_out_reg <= '0;
   end

   assign rk_out    = rk_out_reg;
   assign busy      = (state_reg == ST_EXPAND);
   assign done      = done_reg;
   assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Testbench for key_schedule_seq: directed stimulus with a scoreboard.
// Read results and done pulses are queued at issue time and checked by
// independent monitors when the DUT presents them.
module tb_key_schedule_seq;

   localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KZ      = 128'h0;
   localparam logic [127:0] KZ_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] KZ_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] K_ALT   = 128'h000102030405060708090a0b0c0d0e0f;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic [3:0]   rd_index;
   logic [127:0] rk_out;
   logic         busy;
   logic         done;
   logic         key_valid;

   int n_checks;
   int n_fail;
   int cyc;

   logic           rd_req;
   logic           req_lat;
   logic [127:0]   exp_q[$];
   int             idx_q[$];
   int             done_q[$];

   key_schedule_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_in    (key_in),
      .rd_index  (rd_index),
      .rk_out    (rk_out),
      .busy      (busy),
      .done      (done),
      .key_valid (key_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Read monitor: a read issued before an edge is presented after that edge.
   initial req_lat = 1'b0;
   always @(posedge clk) req_lat <= rd_req;

   always @(negedge clk) begin
      if (req_lat) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: read result with no expectation queued, rk_out=%h", rk_out);
         end else begin
            logic [127:0] e;
            int           ix;
            e  = exp_q.pop_front();
            ix = idx_q.pop_front();
            if (rk_out !== e) begin
               n_fail++;
               $display("FAIL rd_idx%0d: got %h expected %h", ix, rk_out, e);
            end else begin
               $display("rd idx=%0d rk_out=%h ok", ix, rk_out);
            end
         end
      end
   end

   // Done monitor: every done pulse must match a queued cycle number.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_checks++;
         if (done_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: done high at cycle %0d with none expected", cyc);
         end else begin
            int e;
            e = done_q.pop_front();
            if (cyc != e) begin
               n_fail++;
               $display("FAIL done_cycle: got cycle %0d expected cycle %0d", cyc, e);
            end else begin
               $display("done at cycle %0d ok", cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("%s = %h ok", name, act);
      end
   endtask

   // Advance one edge; single-cycle strobes drop right after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      start  = 1'b0;
      rd_req = 1'b0;
   endtask

   task automatic issue_rd(input logic [3:0] idx, input logic [127:0] exp);
      rd_index = idx;
      rd_req   = 1'b1;
      exp_q.push_back(exp);
      idx_q.push_back(int'(idx));
   endtask

   // The accepting edge is the next one; done shows after edge A+10.
   task automatic issue_start(input logic [127:0] key);
      start  = 1'b1;
      key_in = key;
      done_q.push_back(cyc + 11);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      key_in   = '0;
      rd_index = 4'd0;
      rd_req   = 1'b0;

      // Reset state
      tick();
      tick();
      chk("reset_rk_out", rk_out, 128'h0);
      chk("reset_busy", {127'h0, busy}, 128'h0);
      chk("reset_done", {127'h0, done}, 128'h0);
      chk("reset_key_valid", {127'h0, key_valid}, 128'h0);
      rst_n = 1'b1;
      tick();

      // FIPS-197 key, with an ignored start pulse at E3
      issue_start(K1);
      tick();
      chk("e0_busy", {127'h0, busy}, 128'h1);
      chk("e0_key_valid", {127'h0, key_valid}, 128'h0);
      for (int i = 1; i <= 10; i++) begin
         if (i == 3) begin
            start  = 1'b1;
            key_in = K_ALT;
         end
         tick();
         if (i == 9) chk("e9_busy", {127'h0, busy}, 128'h1);
      end
      chk("e10_busy", {127'h0, busy}, 128'h0);
      chk("e10_key_valid", {127'h0, key_valid}, 128'h1);

      // Reads: known keys, out-of-range indices, switching every cycle
      issue_rd(4'd10, K1_RK10);  tick();
      issue_rd(4'd0,  K1);       tick();
      issue_rd(4'd1,  K1_RK1);   tick();
      issue_rd(4'd11, 128'h0);   tick();
      issue_rd(4'd10, K1_RK10);  tick();
      issue_rd(4'd15, 128'h0);   tick();
      issue_rd(4'd1,  K1_RK1);   tick();
      issue_rd(4'd0,  K1);       tick();
      tick();

      // Restart from IDLE while key_valid is high, all-zero key
      issue_start(KZ);
      tick();
      chk("restart_key_valid", {127'h0, key_valid}, 128'h0);
      chk("restart_busy", {127'h0, busy}, 128'h1);
      for (int i = 1; i <= 10; i++) tick();
      chk("restart_key_valid_end", {127'h0, key_valid}, 128'h1);
      issue_rd(4'd1,  KZ_RK1);   tick();
      issue_rd(4'd10, KZ_RK10);  tick();
      issue_rd(4'd0,  KZ);       tick();
      tick();

      // Reset together with start at E5 mid-expansion
      issue_start(K1);
      tick();
      for (int i = 1; i <= 4; i++) tick();
      void'(done_q.pop_back());
      rst_n  = 1'b0;
      start  = 1'b1;
      key_in = K_ALT;
      tick();
      chk("rst_mid_busy", {127'h0, busy}, 128'h0);
      chk("rst_mid_key_valid", {127'h0, key_valid}, 128'h0);
      chk("rst_mid_rk_out", rk_out, 128'h0);
      rst_n = 1'b1;
      issue_rd(4'd10, 128'h0);   tick();
      tick();

      // Fresh start after reset completes normally
      issue_start(K1);
      tick();
      for (int i = 1; i <= 10; i++) tick();
      chk("fresh_key_valid", {127'h0, key_valid}, 128'h1);
      issue_rd(4'd10, K1_RK10);  tick();
      issue_rd(4'd1,  K1_RK1);   tick();
      tick();
      tick();

      // Everything queued must have been seen
      n_checks++;
      if (done_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queues_drained: done pending %0d read pending %0d, required 0 and 0",
                  done_q.size(), exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
